wb_master: RTL and testbench
============================

WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max number of cycles to wait for WB_ACK_I before aborting (legal 1..255).
REQ-002 SHALL have ports:
  WB_CLK_I  in  1  single clock; all state changes on its rising edge.
  WB_RST_I  in  1  reset, asynchronous, active-high.
  CMD_VALID in  1  local side requests a bus cycle.
  CMD_READY out 1  master can accept a command.
  CMD_WE    in  1  1 = write, 0 = read.
  CMD_ADDR  in  8  target address.
  CMD_DATA  in  32 write data.
  RSP_VALID out 1  one-cycle pulse: response available.
  RSP_DATA  out 32 read data; 0 after writes and errors.
  RSP_ERR   out 1  valid with RSP_VALID: cycle aborted by timeout.
  WB_CYC_O  out 1  Wishbone cycle.
  WB_STB_O  out 1  Wishbone strobe.
  WB_WE_O   out 1  Wishbone write enable.
  WB_ADR_O  out 8  Wishbone address.
  WB_DAT_O  out 32 Wishbone write data.
  WB_DAT_I  in  32 Wishbone read data.
  WB_ACK_I  in  1  Wishbone acknowledge from the responder.

Function
REQ-003 SHALL implement states IDLE and BUS.
REQ-004 In IDLE: CMD_READY = 1. In BUS: CMD_READY = 0.
REQ-005 A command SHALL be accepted on an edge where CMD_VALID and CMD_READY are both 1.
REQ-006 On acceptance, the master SHALL register CMD_WE, CMD_ADDR and CMD_DATA onto WB_WE_O, WB_ADR_O and WB_DAT_O, set WB_CYC_O = WB_STB_O = 1, clear the timeout counter, and go to BUS.
REQ-007 In BUS, WB_ADR_O, WB_DAT_O and WB_WE_O SHALL stay stable until the cycle ends.
REQ-008 In BUS, on an edge with WB_ACK_I = 1, the master SHALL:
  - clear WB_CYC_O and WB_STB_O;
  - load RSP_DATA with WB_DAT_I for a read, or 0 for a write;
  - set RSP_ERR = 0 and RSP_VALID = 1;
  - return to IDLE.
REQ-009 RSP_VALID SHALL be high for exactly one cycle per completed command; RSP_DATA SHALL hold its value until the next response.
REQ-010 Minimum latency SHALL be: accept at edge N, ACK sampled at edge N+1, RSP_VALID high during cycle N+1..N+2.
REQ-011 A new command SHALL be acceptable in the same cycle RSP_VALID is high (back-to-back); WB_CYC_O then drops for exactly one cycle between bus cycles.
REQ-012 WB_ACK_I SHALL be ignored in IDLE, with no response generated.
REQ-013 CMD_VALID SHALL be ignored in BUS; the command is not lost if the requester holds it until CMD_READY.
REQ-014 WB_DAT_O SHALL be driven with the registered write data on reads as well (don't-care to the slave, no X).

Reset
REQ-015 While WB_RST_I = 1, asynchronously:
  - state = IDLE;
  - WB_CYC_O = WB_STB_O = WB_WE_O = 0;
  - WB_ADR_O = 0, WB_DAT_O = 0;
  - RSP_VALID = RSP_ERR = 0, RSP_DATA = 0;
  - timeout counter = 0;
  - CMD_READY = 0 while reset is asserted.
REQ-016 Reset during BUS SHALL abort the cycle immediately, with no response pulse.
REQ-017 The first command SHALL be acceptable on the first edge after WB_RST_I deasserts.

Configuration
REQ-018 With macro WB_MASTER_TIMEOUT_EN defined:
  - an 8-bit counter increments each BUS cycle without ACK;
  - when it reaches TIMEOUT, the master clears CYC/STB, sets RSP_VALID = 1, RSP_ERR = 1, RSP_DATA = 0, and returns to IDLE;
  - if ACK and timeout coincide on the same edge, ACK wins (RSP_ERR = 0).
REQ-019 Without WB_MASTER_TIMEOUT_EN, no counter SHALL exist, RSP_ERR SHALL be tied 0, and BUS SHALL wait indefinitely for ACK.

Verification
REQ-020 Write: CMD_WE=1, ADDR=0x12, DATA=0xDEADBEEF, slave ACKs in 1 cycle -> CYC/STB high one cycle, WB_ADR_O=0x12, WB_DAT_O=0xDEADBEEF, WB_WE_O=1; RSP_VALID pulse, RSP_DATA=0, RSP_ERR=0.
REQ-021 Read with wait states: ADDR=0x40, slave ACKs after 3 cycles with 0xCAFEF00D -> CYC high 4 cycles, address stable throughout; RSP_DATA=0xCAFEF00D, single RSP_VALID pulse.
REQ-022 Back-to-back: two commands, second presented during RSP_VALID -> second accepted that edge; CYC low exactly one cycle between cycles; two RSP_VALID pulses.
REQ-023 Timeout (macro on, TIMEOUT=16): slave never ACKs -> CYC drops after 16 cycles; RSP_VALID=1, RSP_ERR=1, RSP_DATA=0; CMD_READY=1 next cycle. Macro off: CYC still high after 1000 cycles.
REQ-024 Reset mid-BUS: assert WB_RST_I 2 cycles into a read -> CYC/STB low immediately (async), no RSP_VALID; the next command completes normally.
REQ-025 Stray ACK: pulse WB_ACK_I in IDLE -> no RSP_VALID, state remains IDLE.

Source files
------------

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic bus master.
// Takes one command at a time from a valid/ready local port. It runs one
// Wishbone cycle per command and returns a one-cycle response pulse.
// Optional build macro WB_MASTER_TIMEOUT_EN adds an ACK timeout. When the
// timeout fires, the cycle is aborted and RSP_ERR is set. Without the macro,
// the master waits for ACK forever and RSP_ERR is tied low.
//
// state | meaning
// IDLE  | ready for a command; the bus is released
// BUS   | Wishbone cycle in flight, waiting for WB_ACK_I
module wb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        WB_CLK_I,
  input  logic        WB_RST_I,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [7:0]  CMD_ADDR,
  input  logic [31:0] CMD_DATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        WB_CYC_O,
  output logic        WB_STB_O,
  output logic        WB_WE_O,
  output logic [7:0]  WB_ADR_O,
  output logic [31:0] WB_DAT_O,
  input  logic [31:0] WB_DAT_I,
  input  logic        WB_ACK_I
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_master: TIMEOUT must be in 1..255");
  end

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       rsp_err_q, rsp_err_d;

  // The counter holds the number of ACK-less BUS cycles already completed.
  // The abort happens on the edge that would bring the count up to TIMEOUT.
  assign timeout_hit = (state_q == BUS) && !WB_ACK_I && (cnt_q == TIMEOUT_LAST);

  // Next-state logic for the timeout counter and the error flag. ACK beats a
  // timeout that lands on the same edge.
  always_comb begin
    cnt_d     = cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == IDLE) begin
      if (CMD_VALID) cnt_d = 8'd0;
    end else if (WB_ACK_I) begin
      rsp_err_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (timeout_hit) rsp_err_d = 1'b1;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      cnt_q     <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign RSP_ERR     = 1'b0;
`endif

  // Next-state and bus register logic. Bus fields hold their value unless a
  // new command is accepted.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          we_d    = CMD_WE;
          adr_d   = CMD_ADDR;
          dat_d   = CMD_DATA;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (WB_ACK_I) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? 32'd0 : WB_DAT_I;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. An async reset aborts any cycle in flight
  // without producing a response.
  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 8'd0;
      dat_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign CMD_READY = (state_q == IDLE) && !WB_RST_I;
  assign WB_CYC_O  = cyc_q;
  assign WB_STB_O  = cyc_q;
  assign WB_WE_O   = we_q;
  assign WB_ADR_O  = adr_q;
  assign WB_DAT_O  = dat_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed testbench for wb_master with the default TIMEOUT of 16.
// Inputs are driven 1 ns after a rising edge. Outputs are sampled at the
// same point, so they show the result of that edge.
module tb_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [7:0]  adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i = 32'd0;
  logic        ack = 1'b0;

  int checks = 0;
  int failures = 0;

  wb_master #(.TIMEOUT(16)) dut (
    .WB_CLK_I (clk),
    .WB_RST_I (rst),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_WE   (cmd_we),
    .CMD_ADDR (cmd_addr),
    .CMD_DATA (cmd_data),
    .RSP_VALID(rsp_valid),
    .RSP_DATA (rsp_data),
    .RSP_ERR  (rsp_err),
    .WB_CYC_O (cyc),
    .WB_STB_O (stb),
    .WB_WE_O  (we),
    .WB_ADR_O (adr),
    .WB_DAT_O (dat_o),
    .WB_DAT_I (dat_i),
    .WB_ACK_I (ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_adr", {24'd0, adr}, 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Write, with a 1-cycle ACK
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h12; cmd_data = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0;
    chk("wr_cyc_stb", {30'd0, cyc, stb}, 32'd3);
    chk("wr_we", {31'd0, we}, 32'd1);
    chk("wr_adr", {24'd0, adr}, 32'h12);
    chk("wr_dat_o", dat_o, 32'hDEADBEEF);
    chk("wr_ready_busy", {31'd0, cmd_ready}, 32'd0);
    ack = 1'b1; dat_i = 32'h99999999;
    tick();
    ack = 1'b0;
    chk("wr_cyc_drop", {30'd0, cyc, stb}, 32'd0);
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_data", rsp_data, 32'd0);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_ready_back", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("wr_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);

    // Read with 3 wait states; write data must still be driven on WB_DAT_O
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h40; cmd_data = 32'h11223344;
    tick();
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_data = 32'h0;
    chk("rd_we", {31'd0, we}, 32'd0);
    chk("rd_dat_o", dat_o, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_cyc", {31'd0, cyc}, 32'd1);
      chk("rd_wait_adr", {24'd0, adr}, 32'h40);
      chk("rd_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("rd_cyc_4th", {31'd0, cyc}, 32'd1);
    chk("rd_adr_4th", {24'd0, adr}, 32'h40);
    ack = 1'b1; dat_i = 32'hCAFEF00D;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("rd_cyc_drop", {31'd0, cyc}, 32'd0);
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_data", rsp_data, 32'hCAFEF00D);
    tick();
    chk("rd_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    chk("rd_rsp_data_hold", rsp_data, 32'hCAFEF00D);

    // Back-to-back; the second command is held during BUS and must be ignored there
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h21; cmd_data = 32'h00000001;
    tick();
    cmd_we = 1'b0; cmd_addr = 8'h22; cmd_data = 32'h00000002;
    ack = 1'b1; dat_i = 32'h00000055;
    tick();
    ack = 1'b0;
    chk("b2b_gap_cyc", {31'd0, cyc}, 32'd0);
    chk("b2b_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp1_data", rsp_data, 32'd0);
    chk("b2b_adr_held", {24'd0, adr}, 32'h21);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_second_cyc", {31'd0, cyc}, 32'd1);
    chk("b2b_second_adr", {24'd0, adr}, 32'h22);
    chk("b2b_second_we", {31'd0, we}, 32'd0);
    chk("b2b_rsp1_pulse_end", {31'd0, rsp_valid}, 32'd0);
    ack = 1'b1; dat_i = 32'hA5A5A5A5;
    tick();
    ack = 1'b0;
    chk("b2b_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_rsp2_data", rsp_data, 32'hA5A5A5A5);
    tick();

    // Reset 2 cycles into a read
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h33; cmd_data = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_rst_cyc_before", {31'd0, cyc}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc_async", {30'd0, cyc, stb}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_adr", {24'd0, adr}, 32'h0);
    tick();
    rst = 1'b0;
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h44; cmd_data = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    chk("post_rst_cyc", {31'd0, cyc}, 32'd1);
    chk("post_rst_dat_o", dat_o, 32'h12345678);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd1);
    tick();

    // Stray ACK in IDLE
    ack = 1'b1; dat_i = 32'h77777777;
    tick();
    ack = 1'b0;
    chk("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("stray_idle", {30'd0, cyc, cmd_ready}, 32'd1);
    tick();
    chk("stray_no_rsp2", {31'd0, rsp_valid}, 32'd0);
    chk("stray_data_hold", rsp_data, 32'h0);

`ifdef WB_MASTER_TIMEOUT_EN
    // The slave never ACKs, so CYC must stay high for exactly 16 cycles
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h55;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_cyc_held", {31'd0, cyc}, 32'd1);
      chk("to_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("to_cyc_drop", {31'd0, cyc}, 32'd0);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    // ACK on the same edge as the timeout: ACK must win
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    ack = 1'b1; dat_i = 32'h0BADF00D;
    tick();
    ack = 1'b0;
    chk("to_tie_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_tie_err", {31'd0, rsp_err}, 32'd0);
    chk("to_tie_data", rsp_data, 32'h0BADF00D);
    tick();
`else
    // Without the timeout, the master must wait indefinitely
    begin
      int seen_rsp;
      seen_rsp = 0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h55;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (rsp_valid) seen_rsp++;
        tick();
      end
      chk("noto_cyc_held", {31'd0, cyc}, 32'd1);
      chk("noto_no_rsp", seen_rsp, 32'd0);
      ack = 1'b1; dat_i = 32'h600DF00D;
      tick();
      ack = 1'b0;
      chk("noto_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("noto_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("noto_rsp_data", rsp_data, 32'h600DF00D);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
